// File: rtl/fmap_bank_pkg.sv
// Shared types and default sizing for the feature-map bank buffer.
package fmap_bank_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_NUM_BANKS  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Bank pointer width: at least one bit even for small bank counts.
  function automatic int bank_width(input int num_banks);
    return (num_banks > 2) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/mem_bank_sdp.sv
// One simple-dual-port bank: one write port, one registered read port.
module mem_bank_sdp
  import fmap_bank_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  DEPTH      = DEF_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port; a same-address read sees the old word.
  // NOTE: neither the array nor rdata is reset so the bank maps onto block RAM;
  // the owner zeroes contents by sweeping addresses instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fmap_bank_buffer.sv
// Ping-pong feature-map buffer: NUM_BANKS banks, bulk clear and preload,
// user writes into the write bank, reads from the bank behind it.
module fmap_bank_buffer
  import fmap_bank_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  DEPTH      = DEF_DEPTH,
  parameter int  NUM_BANKS  = DEF_NUM_BANKS,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BANK_WIDTH = bank_width(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csen,
  input  logic                  clr_start,
  input  logic                  load_start,
  input  logic [BANK_WIDTH-1:0] load_bank,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_done,
  input  logic                  swap,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic [BANK_WIDTH-1:0] wr_bank
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(NUM_BANKS - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [BANK_WIDTH-1:0] load_bank_q;
  logic [BANK_WIDTH-1:0] rd_bank;
  logic [BANK_WIDTH-1:0] rd_bank_q;
  logic                  rd_fire;
  logic                  rd_in_range;
  logic                  rd_in_range_q;
  logic                  wr_in_range;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  assign rd_fire     = rd_en & csen;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
  assign rd_bank     = (wr_bank == '0) ? LAST_BANK : wr_bank - BANK_WIDTH'(1);

  // Control FSM: clear sweep, preload stream, bank pointer rotation.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_CLEAR;
      cnt         <= '0;
      load_bank_q <= '0;
      wr_bank     <= '0;
      busy        <= 1'b1;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end else if (load_start) begin
            state       <= ST_LOAD;
            cnt         <= '0;
            load_bank_q <= load_bank;
            busy        <= 1'b1;
            load_ready  <= 1'b1;
          end
          if (swap) wr_bank <= (wr_bank == LAST_BANK) ? '0 : wr_bank + BANK_WIDTH'(1);
        end
        ST_CLEAR: begin
          if (cnt == LAST_ADDR) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            if (load_last || cnt == LAST_ADDR) begin
              state      <= ST_IDLE;
              cnt        <= '0;
              busy       <= 1'b0;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end else begin
              cnt <= cnt + ADDR_WIDTH'(1);
            end
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

  // Read pipeline: remember bank and range of the request for the data mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid      <= 1'b0;
      rd_in_range_q <= 1'b0;
      rd_bank_q     <= '0;
    end else begin
      rd_valid      <= rd_fire;
      rd_in_range_q <= rd_in_range;
      rd_bank_q     <= rd_bank;
    end
  end

  assign rd_data = (rd_valid && rd_in_range_q) ? bank_rdata[rd_bank_q] : '0;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    // Write-port owner per state: clear sweep, preload stream or user write.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
      we    = 1'b0;
      waddr = cnt;
      wdata = '0;
      case (state)
        ST_CLEAR: we = 1'b1;
        ST_LOAD: begin
          we    = load_valid && (load_bank_q == BANK_WIDTH'(b));
          wdata = load_data;
        end
        ST_IDLE: begin
          we    = wr_en && csen && wr_in_range && (wr_bank == BANK_WIDTH'(b));
          waddr = wr_addr;
          wdata = wr_data;
        end
        default: ;
      endcase
    end

    mem_bank_sdp #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_bank (
      .clk  (clk),
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .re   (rd_fire && rd_in_range),
      .raddr(rd_addr),
      .rdata(rdata)
    );

    assign bank_rdata[b] = rdata;
  end

endmodule

// File: tb/tb_fmap_bank_buffer.sv
// Scoreboard bench for fmap_bank_buffer at DATA_WIDTH=8, DEPTH=16, NUM_BANKS=2.
module tb_fmap_bank_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NB    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          csen = 1'b1;
  logic          clr_start = 1'b0;
  logic          load_start = 1'b0;
  logic [0:0]    load_bank = '0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          load_done;
  logic          swap = 1'b0;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [3:0]    rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic [0:0]    wr_bank;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] sb_q[$];
  logic          rd_fire_d = 1'b0;
  bit            mon_en = 1'b0;

  fmap_bank_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .NUM_BANKS (NB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .csen      (csen),
    .clr_start (clr_start),
    .load_start(load_start),
    .load_bank (load_bank),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .load_done (load_done),
    .swap      (swap),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .wr_bank   (wr_bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Remember whether a read was issued so its response slot can be checked.
  always @(posedge clk) rd_fire_d <= rd_en & csen;

  // Response monitor: one-cycle latency, data popped from the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rd_valid", rd_valid, rd_fire_d);
      if (rd_valid) begin
        check("sb_has_entry", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) check("rd_data", rd_data, sb_q.pop_front());
      end else begin
        check("rd_data_idle", rd_data, 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input logic [DW-1:0] exp);
    rd_en = 1'b1; csen = 1'b1; rd_addr = a;
    sb_q.push_back(exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; csen = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_swap(input logic [0:0] exp_bank);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    check("wr_bank_swap", wr_bank, exp_bank);
  endtask

  // Count sampled cycles with busy high; load_ready/load_done must stay low.
  task automatic count_busy(input string tag);
    int n = 0;
    while (busy && n < 64) begin
      n++;
      check("busy_no_ready", load_ready, 0);
      check("busy_no_done", load_done, 0);
      tick();
    end
    check(tag, n, DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and automatic clear.
    tick(); tick();
    mon_en = 1'b1;
    check("rst_busy", busy, 1);
    check("rst_wr_bank", wr_bank, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_done", load_done, 0);
    rst = 1'b0;
    count_busy("por_busy_cycles");
    for (int i = 0; i < DEPTH; i++) rd(4'(i), 8'h00);

    // Write into bank 0, rotate twice.
    wr(4'd3, 8'hA5);
    do_swap(1'b1);
    rd(4'd3, 8'hA5);
    do_swap(1'b0);
    rd(4'd3, 8'h00);
    do_swap(1'b1);

    // Full preload of bank 1 without load_last.
    load_start = 1'b1; load_bank = 1'b1;
    tick();
    load_start = 1'b0;
    check("load_busy", busy, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check("load_ready", load_ready, 1);
      check("load_done_early", load_done, 0);
      load_valid = 1'b1; load_data = 8'(8'h10 + i);
      tick();
    end
    load_valid = 1'b0;
    check("load_done_full", load_done, 1);
    check("load_ready_after", load_ready, 0);
    check("load_busy_after", busy, 0);
    tick();
    check("load_done_pulse", load_done, 0);
    rd(4'd5, 8'h00);
    do_swap(1'b0);
    rd(4'd5, 8'h15);

    // Swap in the read cycle: the read still uses the old read bank.
    rd_en = 1'b1; rd_addr = 4'd6; swap = 1'b1;
    sb_q.push_back(8'h16);
    tick();
    rd_en = 1'b0; swap = 1'b0;
    check("wr_bank_rd_swap", wr_bank, 1);
    rd(4'd6, 8'h00);

    // Read-first while a short preload overwrites the word being read.
    wr(4'd7, 8'h11);
    do_swap(1'b0);
    rd(4'd7, 8'h11);
    load_start = 1'b1; load_bank = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("short_load_done_early", load_done, 0);
      load_valid = 1'b1;
      load_data = (i == 7) ? 8'h3C : 8'(8'h30 + i);
      load_last = (i == 7);
      if (i == 7) begin
        rd_en = 1'b1; rd_addr = 4'd7;
        sb_q.push_back(8'h11);
      end
      tick();
      rd_en = 1'b0;
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("short_load_done", load_done, 1);
    check("short_load_busy", busy, 0);
    rd(4'd7, 8'h3C);
    rd(4'd6, 8'h36);
    rd(4'd8, 8'h18);

    // Clear and load requested together: clear wins.
    clr_start = 1'b1; load_start = 1'b1; load_bank = 1'b0;
    tick();
    clr_start = 1'b0; load_start = 1'b0;
    count_busy("clr_busy_cycles");
    for (int i = 0; i < DEPTH; i++) rd(4'(i), 8'h00);

    // Chip select gates both strobes.
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h77;
    rd_en = 1'b1; rd_addr = 4'd2; csen = 1'b0;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; csen = 1'b1;
    wr(4'd9, 8'h42);
    do_swap(1'b1);
    rd(4'd2, 8'h00);
    rd(4'd9, 8'h42);
    rd(4'd3, 8'h00);

    // Reset during the fifth preload word.
    load_start = 1'b1; load_bank = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("abort_load_done", load_done, 0);
      load_valid = 1'b1; load_data = 8'(8'h50 + i);
      if (i == 4) rst = 1'b1;
      tick();
    end
    rst = 1'b0; load_valid = 1'b0;
    check("abort_wr_bank", wr_bank, 0);
    count_busy("abort_busy_cycles");
    for (int i = 0; i < 4; i++) rd(4'(i), 8'h00);

    tick(); tick(); tick();
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmap_bank_buffer.md
FMAP_BANK_BUFFER -- requirements
Module: fmap_bank_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter DEPTH, default 1024, words per bank (>=2).
REQ-003 Parameter NUM_BANKS, default 2, bank count (>=2); ADDR_WIDTH = clog2(DEPTH), BANK_WIDTH = max(1, clog2(NUM_BANKS)), both derived.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 csen  in  1  chip select; gates rd_en and wr_en.
REQ-007 clr_start  in  1  pulse: zero all banks.
REQ-008 load_start  in  1  pulse: begin preload of bank load_bank.
REQ-009 load_bank  in  BANK_WIDTH  preload target bank, sampled with load_start.
REQ-010 load_valid  in  1  preload word valid.
REQ-011 load_data  in  DATA_WIDTH  preload word.
REQ-012 load_last  in  1  final preload word, qualified by load_valid.
REQ-013 load_ready  out  1  preload word accepted when load_valid & load_ready.
REQ-014 load_done  out  1  one-cycle pulse at preload end.
REQ-015 swap  in  1  pulse: advance ping-pong bank pointers.
REQ-016 wr_en  in  1  write strobe.
REQ-017 wr_addr  in  ADDR_WIDTH  write address in current write bank.
REQ-018 wr_data  in  DATA_WIDTH  write data.
REQ-019 rd_en  in  1  read strobe.
REQ-020 rd_addr  in  ADDR_WIDTH  read address in current read bank.
REQ-021 rd_data  out  DATA_WIDTH  registered read data.
REQ-022 rd_valid  out  1  rd_data valid.
REQ-023 busy  out  1  high in CLEAR or LOAD.
REQ-024 wr_bank  out  BANK_WIDTH  current write bank pointer.

Function
REQ-025 FSM states IDLE, CLEAR, LOAD; user writes accepted only in IDLE.
REQ-026 CLEAR: counter 0..DEPTH-1, one address per cycle zeroed in all banks in parallel; exactly DEPTH cycles, then IDLE.
REQ-027 LOAD: each accepted word written to load_bank at load counter, counter +1; exit to IDLE with load_done after load_last accepted or DEPTH-th word accepted, whichever first.
REQ-028 load_ready = 1 only in LOAD; unfilled addresses retain prior contents.
REQ-029 clr_start and load_start in same cycle: clear wins, load dropped; both ignored when not IDLE.
REQ-030 Read bank = (wr_bank + NUM_BANKS - 1) mod NUM_BANKS.
REQ-031 swap in IDLE: wr_bank <= (wr_bank + 1) mod NUM_BANKS, wrap at NUM_BANKS-1 to 0; swap ignored in CLEAR/LOAD.
REQ-032 Write: wr_en & csen & IDLE & wr_addr < DEPTH -> word stored at next edge; otherwise no change.
REQ-033 Read latency 1: rd_en & csen in cycle N -> rd_valid=1, rd_data=mem[read bank][rd_addr] in N+1; otherwise rd_valid=0, rd_data=0.
REQ-034 Reads allowed in every state; rd_addr >= DEPTH -> rd_valid=1, rd_data=0.
REQ-035 Same-cycle read and write to the same bank/address: read-first (old data).
REQ-036 Read bank captured in the rd_en cycle; a swap in that cycle affects only later reads.

Reset
REQ-037 rst high at a clock edge: rd_data=0, rd_valid=0, load_ready=0, load_done=0, wr_bank=0, counters=0, state=CLEAR, busy=1.
REQ-038 After rst deasserts, CLEAR runs DEPTH cycles automatically; busy falls to 0 after completion.
REQ-039 rst mid-LOAD or mid-CLEAR aborts the operation and restarts CLEAR from address 0.

Structure
REQ-040 Package fmap_bank_pkg holds FSM state enum and default parameter constants.
REQ-041 One sub-module mem_bank_sdp: single simple-dual-port registered-read bank, instantiated NUM_BANKS times, block-RAM inferable (no reset on array).

Verification (DATA_WIDTH=8, DEPTH=16, NUM_BANKS=2)
REQ-042 Release rst -> busy=1 exactly 16 cycles; then any read returns 0x00, rd_valid=1 one cycle later.
REQ-043 load_start, load_bank=1, stream 0x10..0x1F without load_last -> load_done after 16th word, load_ready=0; swap once, then read addr 5 -> 0x15.
REQ-044 Write 0xA5 to addr 3, then swap twice -> wr_bank 0->1->0; read addr 3 after the first swap returns 0xA5, after the second 0x00.
REQ-045 Same-cycle write 0x3C and read of addr 7 in the same bank holding 0x11 -> rd_data=0x11, next read 0x3C.
REQ-046 clr_start and load_start together -> CLEAR 16 cycles, no load_ready, memory all 0x00.
REQ-047 rst asserted at LOAD word 4 -> load_done never pulses, busy=1 16 cycles, addr 0-3 read 0x00.
